// File: rtl/adder_8bit.sv
// Registered 8-bit ripple-carry adder: {Cout, S} = A + B + Cin, loaded every rising clk edge.
// Outputs clear asynchronously while rst_n is low.
module adder_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Cin,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic       Cout,
  output logic [7:0] S
);

  // One full-adder cell; returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    logic p;
    p = a ^ b;
    return {(a & b) | (c & p), p ^ c};
  endfunction

  logic [8:0] carry_s;
  logic [7:0] sum_s;

  // Ripple chain of eight cells, carry entering at Cin and leaving as carry_s[8].
  always_comb begin
    carry_s    = 9'h000;
    sum_s      = 8'h00;
    carry_s[0] = Cin;
    for (int i = 0; i < 8; i++) begin
      {carry_s[i+1], sum_s[i]} = full_add(A[i], B[i], carry_s[i]);
    end
  end

  // Result registers; no enable, so every edge out of reset loads a new sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S    <= 8'h00;
      Cout <= 1'b0;
    end else begin
      S    <= sum_s;
      Cout <= carry_s[8];
    end
  end

endmodule

// File: tb/tb_adder_8bit.sv
// Directed and random checks of adder_8bit using a queue of expected {Cout, S} results.
module tb_adder_8bit;

  logic       clk;
  logic       rst_n;
  logic       Cin;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cout;
  logic [7:0] S;

  int vectors     = 0;
  int miscompares = 0;
  logic [8:0] exp_q[$];

  adder_8bit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .Cin  (Cin),
    .A    (A),
    .B    (B),
    .Cout (Cout),
    .S    (S)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [8:0] observed, input logic [8:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive operands away from the active edge and queue the reference sum.
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    A   = a;
    B   = b;
    Cin = c;
    exp_q.push_back({1'b0, a} + {1'b0, b} + {8'h00, c});
  endtask

  // Sample just after the active edge and compare with the oldest queued result.
  task automatic collect(input string tag);
    logic [8:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed empty-queue expected queued result", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, {Cout, S}, e);
    end
  endtask

  task automatic apply(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c);
    drive(a, b, c);
    collect(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    A     = 8'hFF;
    B     = 8'hFF;
    Cin   = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", {Cout, S}, 9'h000);
    end

    @(negedge clk);
    rst_n = 1'b1;

    apply("zero_cin0",  8'h00, 8'h00, 1'b0);
    check("zero_cin0_const", {Cout, S}, 9'h000);
    apply("small_cin0", 8'h02, 8'h03, 1'b0);
    check("small_cin0_const", {Cout, S}, 9'h005);
    apply("max_cin0",   8'hFF, 8'hFF, 1'b0);
    check("max_cin0_const", {Cout, S}, 9'h1FE);
    apply("zero_cin1",  8'h00, 8'h00, 1'b1);
    check("zero_cin1_const", {Cout, S}, 9'h001);
    apply("small_cin1", 8'h02, 8'h03, 1'b1);
    check("small_cin1_const", {Cout, S}, 9'h006);
    apply("max_cin1",   8'hFF, 8'hFF, 1'b1);
    check("max_cin1_const", {Cout, S}, 9'h1FF);
    apply("full_ripple", 8'hFF, 8'h00, 1'b1);
    check("full_ripple_const", {Cout, S}, 9'h100);
    apply("alt_bits",   8'hAA, 8'h55, 1'b1);
    apply("alt_bits2",  8'h55, 8'h55, 1'b0);

    // Outputs must hold between edges even though inputs change.
    drive(8'h01, 8'h01, 1'b0);
    check("hold_between_edges", {Cout, S}, 9'h0AA);
    collect("after_hold");

    for (int i = 0; i < 40; i++) begin
      apply("random", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    apply("pre_reset", 8'hFF, 8'hFF, 1'b0);
    check("pre_reset_const", {Cout, S}, 9'h1FE);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {Cout, S}, 9'h000);
    @(posedge clk);
    #1;
    check("reset_clocked", {Cout, S}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_reset", 8'h02, 8'h03, 1'b0);
    check("post_reset_const", {Cout, S}, 9'h005);

    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL queue_drain: observed %0d left expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
